// File: rtl/rr_task_cluster.sv
// Cluster of NUM_INST countdown worker slots fed by a round-robin dispatcher.
// A round-robin completion arbiter holds its grant stable under downstream backpressure.
module rr_task_cluster #(
    parameter int  NUM_INST = 5,
    parameter int  CNT_W    = 8,
    localparam int ID_W     = $clog2(NUM_INST)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CNT_W-1:0]    in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_W-1:0]     out_id,
    output logic [NUM_INST-1:0] busy_mask,
    output logic                idle
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } slot_state_t;

    // Index base+off modulo NUM_INST; base is always below NUM_INST and off never exceeds it.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        s = (s >= NUM_INST) ? (s - NUM_INST) : s;
        return ID_W'(s);
    endfunction

    logic [NUM_INST-1:0] w_idle_vec;
    logic [NUM_INST-1:0] w_done_vec;
    logic [NUM_INST-1:0] w_load;
    logic [NUM_INST-1:0] w_release;
    logic                w_accept;
    logic                w_complete;
    logic [ID_W-1:0]     w_disp_sel;
    logic [ID_W-1:0]     w_cpl_sel;
    logic [CNT_W-1:0]    w_len_eff;

    logic [ID_W-1:0]     r_disp_ptr;
    logic [ID_W-1:0]     r_cpl_ptr;
    logic                r_lock;
    logic [ID_W-1:0]     r_lock_id;

    assign w_len_eff  = (in_len == {CNT_W{1'b0}}) ? CNT_W'(1) : in_len;
    assign in_ready   = |w_idle_vec;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = |w_done_vec;
    assign out_id     = r_lock ? r_lock_id : w_cpl_sel;
    assign w_complete = out_valid && out_ready;
    assign busy_mask  = ~w_idle_vec;
    assign idle       = (busy_mask == {NUM_INST{1'b0}});

    for (genvar gi = 0; gi < NUM_INST; gi++) begin : g_slot
        slot_state_t      r_state;
        slot_state_t      w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;

        // Slot state and countdown register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= {CNT_W{1'b0}};
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Slot next-state: load on dispatch, count down in RUN, wait for release in DONE.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_load[gi]) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_len_eff;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (w_release[gi]) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end

        assign w_idle_vec[gi] = (r_state == S_IDLE);
        assign w_done_vec[gi] = (r_state == S_DONE);
        assign w_load[gi]     = w_accept && (w_disp_sel == ID_W'(gi));
        assign w_release[gi]  = w_complete && (out_id == ID_W'(gi));
    end

    // Dispatch pick: scanning downward lets the candidate nearest the pointer win.
    always_comb begin
        w_disp_sel = r_disp_ptr;
        for (int k = NUM_INST - 1; k >= 0; k--) begin
            if (w_idle_vec[wrap_idx(r_disp_ptr, k)]) begin
                w_disp_sel = wrap_idx(r_disp_ptr, k);
            end else begin
                w_disp_sel = w_disp_sel;
            end
        end
    end

    // Completion pick, same rotating-priority scan over DONE slots.
    always_comb begin
        w_cpl_sel = {ID_W{1'b0}};
        for (int k = NUM_INST - 1; k >= 0; k--) begin
            if (w_done_vec[wrap_idx(r_cpl_ptr, k)]) begin
                w_cpl_sel = wrap_idx(r_cpl_ptr, k);
            end else begin
                w_cpl_sel = w_cpl_sel;
            end
        end
    end

    // Round-robin pointers and the completion grant lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_ptr <= {ID_W{1'b0}};
            r_cpl_ptr  <= {ID_W{1'b0}};
            r_lock     <= 1'b0;
            r_lock_id  <= {ID_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_disp_ptr <= wrap_idx(w_disp_sel, 1);
            end else begin
                r_disp_ptr <= r_disp_ptr;
            end
            if (w_complete) begin
                r_lock    <= 1'b0;
                r_cpl_ptr <= wrap_idx(out_id, 1);
            end else if (out_valid) begin
                r_lock    <= 1'b1;
                r_lock_id <= out_id;
            end else begin
                r_lock    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_task_cluster.sv
// Random and directed bench for rr_task_cluster against a time-stamp based reference model.
module tb_rr_task_cluster;
    localparam int N = 5;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_len;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_id;
    logic [N-1:0] busy_mask;
    logic         idle;

    rr_task_cluster dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .busy_mask (busy_mask),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a slot is busy from dispatch until its completion is consumed, and
    // reports done once the edge count reaches its finish time.
    bit m_busy [N];
    int m_done_at [N];
    int m_now, m_dptr, m_cptr, m_lock_id;
    bit m_lock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_done_at[i] = 0;
        end
        m_now = 0; m_dptr = 0; m_cptr = 0; m_lock = 1'b0; m_lock_id = 0;
    endfunction

    function automatic bit m_is_done(input int i);
        return m_busy[i] && (m_now >= m_done_at[i]);
    endfunction

    function automatic bit m_any_done();
        for (int i = 0; i < N; i++) if (m_is_done(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_out_id();
        if (m_lock) return m_lock_id;
        for (int k = 0; k < N; k++) if (m_is_done((m_cptr + k) % N)) return (m_cptr + k) % N;
        return 0;
    endfunction

    function automatic bit m_in_ready();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_check();
        logic [N-1:0] eb;
        for (int i = 0; i < N; i++) eb[i] = m_busy[i];
        chk("in_ready", in_ready, m_in_ready());
        chk("busy_mask", busy_mask, eb);
        chk("idle", idle, eb == '0);
        chk("out_valid", out_valid, m_any_done());
        if (m_any_done()) chk("out_id", out_id, m_out_id());
    endtask

    function automatic void model_edge(input bit v, input logic [7:0] len, input bit rdy);
        bit acc, ev;
        int sel, eid, l;
        acc = v && m_in_ready();
        ev  = m_any_done();
        eid = m_out_id();
        sel = -1;
        if (acc) begin
            for (int k = N - 1; k >= 0; k--) if (!m_busy[(m_dptr + k) % N]) sel = (m_dptr + k) % N;
        end
        if (ev && rdy) begin
            m_busy[eid] = 1'b0; m_lock = 1'b0; m_cptr = (eid + 1) % N;
        end else if (ev) begin
            m_lock = 1'b1; m_lock_id = eid;
        end
        if (acc) begin
            l = (len == 8'd0) ? 1 : int'(len);
            m_busy[sel] = 1'b1;
            m_done_at[sel] = m_now + 1 + l;
            m_dptr = (sel + 1) % N;
        end
        m_now++;
    endfunction

    // Drive one cycle at the falling edge, check the model, then advance across the rising edge.
    task automatic step(input bit v, input logic [7:0] len, input bit rdy);
        @(negedge clk);
        in_valid = v; in_len = len; out_ready = rdy;
        #1;
        model_check();
        model_edge(v, len, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_len = 8'd0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset();

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy_mask, 5'b00000);
        chk("rst_out_id", out_id, 3'd0);
        repeat (3) step(1'b0, 8'd0, 1'b0);

        // Single task of length 3
        step(1'b1, 8'd3, 1'b1);
        chk("t2_busy", busy_mask, 5'b00001);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("t2_not_yet", out_valid, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_id", out_id, 3'd0);
        step(1'b0, 8'd0, 1'b1);
        chk("t2_freed", busy_mask, 5'b00000);

        // Five length-10 tasks then a sixth that must stall
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'd10, 1'b1);
        chk("t3_full", busy_mask, 5'b11111);
        chk("t3_stall", in_ready, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'd10, 1'b1);
        chk("t3_still_stall", in_ready, 1'b0);
        chk("t3_s0_done", out_id, 3'd0);
        step(1'b1, 8'd10, 1'b1);
        chk("t3_s0_free", busy_mask, 5'b11110);
        step(1'b1, 8'd10, 1'b1);
        chk("t3_sixth_in_s0", busy_mask, 5'b11101);
        repeat (20) step(1'b0, 8'd0, 1'b1);

        // Locked grant under backpressure
        do_reset();
        step(1'b1, 8'd4, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        chk("t4_none", out_valid, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("t4_first", out_id, 3'd1);
        repeat (3) step(1'b0, 8'd0, 1'b0);
        chk("t4_held", out_id, 3'd1);
        chk("t4_all_done_busy", busy_mask, 5'b00111);
        step(1'b0, 8'd0, 1'b1);
        chk("t4_second", out_id, 3'd2);
        step(1'b0, 8'd0, 1'b1);
        chk("t4_third", out_id, 3'd0);
        step(1'b0, 8'd0, 1'b1);
        chk("t4_drained", out_valid, 1'b0);

        // Length 0 and length 255
        do_reset();
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("t5_len0_done", out_valid, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd255, 1'b1);
        repeat (254) step(1'b0, 8'd0, 1'b1);
        chk("t5_len255_early", out_valid, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk("t5_len255_done", out_valid, 1'b1);
        chk("t5_len255_id", out_id, 3'd1);
        step(1'b0, 8'd0, 1'b1);

        // Asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'd20, 1'b1);
        repeat (4) step(1'b0, 8'd0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy_mask, 5'b00000);
        chk("t6_idle", idle, 1'b1);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (30) step(1'b0, 8'd0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 14)),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (40) step(1'b0, 8'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
